// File: rtl/bus_pkg.sv
// Shared constants for the single-wire serial bus responders.
// State encoding, field widths, RW polarity and bit order.
package bus_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_WAIT_START = 4'd1,
    ST_ADDR       = 4'd2,
    ST_WDATA      = 4'd3,
    ST_COMMIT     = 4'd4,
    ST_TURN       = 4'd5,
    ST_RDATA      = 4'd6,
    ST_DONE       = 4'd7
  } state_e;

  localparam int   BUS_DATA_W = 8;
  localparam int   BUS_ADDR_W = 12;
  localparam logic RW_WRITE   = 1'b1;
  localparam bit   LSB_FIRST  = 1'b1;

endpackage

// File: rtl/serial_shifter.sv
// Bit counter plus shift register used for both shift-in and shift-out.
// `last` is high during the cycle whose shift completes the word.
module serial_shifter
  import bus_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift_en,
  input  logic         bit_in,
  output logic [W-1:0] data,
  output logic         last
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      cnt_q <= '0;
    end else if (load) begin
      data  <= load_val;
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (shift_en) begin
      data  <= LSB_FIRST ? {bit_in, data[W-1:1]}
                         : {data[W-2:0], bit_in};
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign last = (cnt_q == CW'(W - 1));

endmodule

// File: rtl/reg_bank_slave.sv
// Serial-bus register bank responder (open-drain single-wire line).
// Optional REG_SLAVE_PARITY_EN adds even-parity bits to each field.
module reg_bank_slave
  import bus_pkg::*;
#(
  parameter int DATA_WIDTH  = BUS_DATA_W,
  parameter int ADDRS_WIDTH = BUS_ADDR_W,
  parameter int REG_DEPTH   = 16,
  parameter int TIMEOUT_LEN = 6,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  inout  wire                   data_bus_serial,
  input  logic                  b_RW,
  input  logic                  bus_util,
  input  logic                  arbiter_cmd_in,
  output logic                  busy_out,
  output logic [DATA_WIDTH-1:0] last_wdata,
  output logic [3:0]            state
);

  localparam int IW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

`ifdef REG_SLAVE_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  state_e                  st_q, st_d;
  logic                    rw_q;
  logic [TIMEOUT_LEN-1:0]  to_q;
  logic                    par_q, par_d;
  logic                    rd_par_q;
  logic [DATA_WIDTH-1:0]   regs [REG_DEPTH];

  logic                    line;
  logic                    in_txn, abort, select;
  logic                    a_shift, d_shift;
  logic [ADDRS_WIDTH-1:0]  a_data;
  logic [DATA_WIDTH-1:0]   d_data;
  logic                    a_last, d_last;
  logic [IW-1:0]           idx;
  logic                    a_par_ok, d_par_ok;
  logic                    out_bit, drive_low;
  state_e                  after_addr;

  assign line    = data_bus_serial;
  assign in_txn  = (st_q != ST_IDLE);
  assign abort   = in_txn & bus_util;
  assign select  = ~in_txn & arbiter_cmd_in & ~bus_util;
  assign a_shift = (st_q == ST_ADDR) & ~par_q;
  assign d_shift = ((st_q == ST_WDATA) | (st_q == ST_RDATA))
                   & ~par_q;
  assign idx     = a_data[IW-1:0];

  serial_shifter #(.W(ADDRS_WIDTH)) u_addr_sh (
    .clk      (clk),
    .rst      (rst),
    .clr      (~in_txn),
    .load     (1'b0),
    .load_val ('0),
    .shift_en (a_shift),
    .bit_in   (line),
    .data     (a_data),
    .last     (a_last)
  );

  serial_shifter #(.W(DATA_WIDTH)) u_data_sh (
    .clk      (clk),
    .rst      (rst),
    .clr      (~in_txn),
    .load     (st_q == ST_TURN),
    .load_val (regs[idx]),
    .shift_en (d_shift),
    .bit_in   (line),
    .data     (d_data),
    .last     (d_last)
  );

  assign a_par_ok   = ~(^a_data ^ line);
  assign d_par_ok   = ~(^d_data ^ line);
  assign after_addr = (rw_q == RW_WRITE) ? ST_WDATA : ST_TURN;

  // par_q marks the extra parity cycle inside ADDR/WDATA/RDATA
  always_comb begin
    st_d  = st_q;
    par_d = 1'b0;
    unique case (st_q)
      ST_IDLE:
        if (select) st_d = ST_WAIT_START;
      ST_WAIT_START:
        if (!line)      st_d = ST_ADDR;
        else if (&to_q) st_d = ST_IDLE;
      ST_ADDR:
        if (par_q)
          st_d = a_par_ok ? after_addr : ST_DONE;
        else if (a_last) begin
          if (PAR_EN) par_d = 1'b1;
          else        st_d  = after_addr;
        end
      ST_WDATA:
        if (par_q)
          st_d = d_par_ok ? ST_COMMIT : ST_DONE;
        else if (d_last) begin
          if (PAR_EN) par_d = 1'b1;
          else        st_d  = ST_COMMIT;
        end
      ST_COMMIT: st_d = ST_DONE;
      ST_TURN:   st_d = ST_RDATA;
      ST_RDATA:
        if (par_q) st_d = ST_DONE;
        else if (d_last) begin
          if (PAR_EN) par_d = 1'b1;
          else        st_d  = ST_DONE;
        end
      ST_DONE:   st_d = ST_IDLE;
      default:   st_d = ST_IDLE;
    endcase
    if (abort) begin
      st_d  = ST_IDLE;
      par_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= ST_IDLE;
      rw_q     <= 1'b0;
      to_q     <= '0;
      par_q    <= 1'b0;
      rd_par_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      par_q <= par_d;
      if (select) begin
        rw_q <= b_RW;
        to_q <= '0;
      end else if (st_q == ST_WAIT_START && !(&to_q)) begin
        to_q <= to_q + TIMEOUT_LEN'(1);
      end
      if (st_q == ST_TURN) rd_par_q <= ^regs[idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_DEPTH; i++) regs[i] <= RESET_VAL;
      last_wdata <= RESET_VAL;
    end else if (st_q == ST_COMMIT && !bus_util) begin
      regs[idx]  <= d_data;
      last_wdata <= d_data;
    end
  end

  // open drain: a 1 bit is left to the pullup
  assign out_bit   = par_q ? rd_par_q
                   : (LSB_FIRST ? d_data[0]
                                : d_data[DATA_WIDTH-1]);
  assign drive_low = (st_q == ST_RDATA) & ~bus_util & ~out_bit;

  assign data_bus_serial = drive_low ? 1'b0 : 1'bz;
  assign busy_out        = in_txn;
  assign state           = st_q;

endmodule

// File: tb/tb_reg_bank_slave.sv
// Randomized bench for reg_bank_slave with a register-array model.
// Drives the open-drain line through a pullup, samples on negedge.
module tb_reg_bank_slave;

`ifdef REG_SLAVE_PARITY_EN
  localparam bit P = 1'b1;
`else
  localparam bit P = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       b_rw = 1'b0;
  logic       bus_util = 1'b0;
  logic       cmd = 1'b0;
  logic       tb_low = 1'b0;
  logic       busy;
  logic [7:0] last_wdata;
  logic [3:0] state;
  wire        bus;

  assign bus = tb_low ? 1'b0 : 1'bz;
  pullup (bus);

  always #5 clk = ~clk;

  reg_bank_slave dut (
    .clk             (clk),
    .rst             (rst),
    .data_bus_serial (bus),
    .b_RW            (b_rw),
    .bus_util        (bus_util),
    .arbiter_cmd_in  (cmd),
    .busy_out        (busy),
    .last_wdata      (last_wdata),
    .state           (state)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] mregs [16];
  logic [7:0] mlast;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    mlast = 8'h00;
  endtask

  task automatic nc();
    @(negedge clk);
  endtask

  // select in cycle 0, returns in cycle 1 (WAIT_START)
  task automatic select_txn(input logic rw);
    nc();
    check("pre_idle", state, 0);
    b_rw = rw;
    cmd  = 1'b1;
    nc();
    cmd = 1'b0;
    check("sel_state", state, 1);
    check("sel_busy", busy, 1);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      nc();
      tb_low = ~v[i];
    end
  endtask

  task automatic do_write(input logic [11:0] a,
                          input logic [7:0] d,
                          input int dly,
                          input int abort_bit);
    select_txn(1'b1);
    repeat (dly) nc();
    tb_low = 1'b1;
    send_bits({20'd0, a}, 12);
    if (P) send_bits({31'd0, ^a}, 1);
    for (int i = 0; i < 8; i++) begin
      nc();
      tb_low = ~d[i];
      if (i == abort_bit) begin
        bus_util = 1'b1;
        nc();
        tb_low = 1'b0;
        #1;
        check("abort_state", state, 0);
        check("abort_busy", busy, 0);
        check("abort_bus_z", bus, 1);
        check("abort_last", last_wdata, mlast);
        bus_util = 1'b0;
        return;
      end
    end
    if (P) send_bits({31'd0, ^d}, 1);
    nc();
    tb_low = 1'b0;
    check("commit_state", state, 4);
    nc();
    check("done_state", state, 7);
    check("done_busy", busy, 1);
    nc();
    mregs[a[3:0]] = d;
    mlast = d;
    check("wr_busy_fall", busy, 0);
    check("wr_last", last_wdata, mlast);
  endtask

  task automatic do_read(input logic [11:0] a,
                         input int dly,
                         input int rst_bit);
    logic [7:0] exp;
    logic [7:0] got;
    select_txn(1'b0);
    repeat (dly) nc();
    tb_low = 1'b1;
    send_bits({20'd0, a}, 12);
    if (P) send_bits({31'd0, ^a}, 1);
    nc();
    tb_low = 1'b0;
    #1;
    check("turn_state", state, 5);
    check("turn_z", bus, 1);
    exp = mregs[a[3:0]];
    got = '0;
    for (int i = 0; i < 8; i++) begin
      nc();
      got[i] = bus;
      if (i == rst_bit) begin
        check("rd_bit_pre_rst", bus, exp[i]);
        #2 rst = 1'b1;
        #1;
        check("rst_bus_z", bus, 1);
        check("rst_busy", busy, 0);
        check("rst_state", state, 0);
        check("rst_last", last_wdata, 8'h00);
        model_reset();
        nc();
        rst = 1'b0;
        return;
      end
    end
    check("rd_data", got, exp);
    if (P) nc();
    nc();
    check("rd_done", state, 7);
    nc();
    check("rd_busy_fall", busy, 0);
  endtask

  task automatic do_timeout();
    select_txn(1'b0);
    repeat (63) nc();
    check("to_c64_state", state, 1);
    nc();
    check("to_c65_state", state, 0);
    check("to_busy", busy, 0);
  endtask

  initial begin
    logic [11:0] ra;
    logic [7:0]  rd;
    int          kind;
    model_reset();
    #12;
    check("rst0_state", state, 0);
    check("rst0_busy", busy, 0);
    check("rst0_last", last_wdata, 8'h00);
    check("rst0_bus_z", bus, 1);
    nc();
    rst = 1'b0;

    do_write(12'h005, 8'hE7, 0, -1);
    do_read(12'h005, 0, -1);
    do_write(12'h015, 8'h1D, 1, -1);
    do_read(12'h005, 2, -1);
    do_timeout();
    do_read(12'h005, 0, -1);
    do_write(12'h005, 8'h42, 0, 3);
    do_read(12'h005, 0, -1);

    for (int n = 0; n < 60; n++) begin
      ra   = 12'($urandom);
      rd   = 8'($urandom);
      kind = int'($urandom_range(0, 9));
      if (kind < 5)
        do_write(ra, rd, int'($urandom_range(0, 3)), -1);
      else if (kind < 9)
        do_read(ra, int'($urandom_range(0, 3)), -1);
      else
        do_write(ra, rd, 0, int'($urandom_range(0, 7)));
    end

    do_write(12'h0A3, 8'hE6, 0, -1);
    do_read(12'h0A3, 0, 0);
    do_read(12'h0A3, 0, -1);
    do_read(12'h005, 1, -1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
